data_memory_mc: RTL and testbench
=================================

Name: data_memory_mc

Overview:
- Multi-cycle data memory responder for the MEM stage of the 5-stage pipeline.
- Accepts one load or store per instruction from the EX/MEM register.
- Holds the pipeline with a stall signal for a configurable access latency.
- Presents load data to the MEM/WB register on the cycle the stall drops.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words stored; power of two, minimum 2
LATENCY, 4, cycles from request acceptance to completion; minimum 1
ADDR_W, log2(DEPTH_WORDS), word-index width; derived, not overridden

Ports:
clk_i  input  1  clock; all state updates on the rising edge
rst_i  input  1  reset; asynchronous, active-low
MemRead_i  input  1  load request from the EX/MEM register
MemWrite_i  input  1  store request from the EX/MEM register
addr_i  input  32  byte address; the word index is addr_i[ADDR_W+1:2]
wdata_i  input  32  store data
rdata_o  output  32  load data; valid while ack_o=1 after a load
stall_o  output  1  pipeline hold; freezes PC, IF/ID, ID/EX and EX/MEM
ack_o  output  1  one-cycle pulse marking access completion
err_o  output  1  one-cycle pulse marking a rejected request

Behaviour:
- Reset (rst_i=0, takes effect immediately):
  - state=IDLE, counter=0, rdata_o=0, ack_o=0, err_o=0.
  - stall_o=0 while reset is held.
  - Memory array is not cleared by reset; it is zero at time 0.
- valid_req = (MemRead_i XOR MemWrite_i) AND addr_i[1:0]==0.
- bad_req = (MemRead_i AND MemWrite_i) OR ((MemRead_i OR MemWrite_i) AND addr_i[1:0]!=0).
- stall_o is combinational: 1 when (state==IDLE AND valid_req) OR state==BUSY; 0 otherwise, including in DONE.
- IDLE:
  - On valid_req in cycle T: latch op, word index and wdata_i; counter=LATENCY-1; go to BUSY, or straight to DONE if LATENCY=1.
  - On bad_req: err_o=1 for the next cycle; no access, no stall; remain in IDLE.
  - No request: remain in IDLE.
- BUSY:
  - Decrement the counter each cycle; inputs are ignored.
  - When counter==1 (or on entry with LATENCY=1), at the next edge:
    - store: write the latched word into the array;
    - load: load rdata_o from the array.
  - Then go to DONE.
- DONE (cycle T+LATENCY):
  - ack_o=1, stall_o=0; rdata_o holds the load result.
  - The MEM/WB register captures rdata_o at the end of this cycle.
  - Go to IDLE unconditionally.
  - A request still asserted in DONE is not re-accepted, since it belongs to the completed instruction.
- Latency: stall_o=1 exactly in cycles T..T+LATENCY-1; ack_o=1 in cycle T+LATENCY.
- Back-to-back accesses: the next instruction's request is sampled in IDLE at T+LATENCY+1, giving zero dead cycles beyond DONE.
- rdata_o holds its last load value through stores and idle cycles.
- Addresses beyond DEPTH_WORDS*4 wrap: upper address bits are ignored.
- Store then load to the same word returns the new data; the write commits before the load issues.
- Reset mid-access: the operation is aborted; a store not yet committed is never written; ack_o is not produced.
- Data ports are word-only: no byte or halfword writes.

Test Plan:
- Reset and idle: hold rst_i=0 for 3 cycles with MemRead_i=1 -> stall_o=0, rdata_o=0, ack_o=0; release with no request -> all outputs stay 0.
- Store then load (LATENCY=4): store 0xDEADBEEF to addr 0x10 at T -> stall_o=1 for T..T+3, ack_o at T+4; load 0x10 at T+5 -> ack_o at T+9 with rdata_o=0xDEADBEEF, stall_o=1 for T+5..T+8.
- Wrap and unwritten: store 0x12345678 to 0x400 (DEPTH 256) -> a load of 0x0 returns 0x12345678; a load of 0x20 returns 0x00000000.
- Rejects: MemRead_i=MemWrite_i=1 -> err_o pulse next cycle, stall_o=0, array unchanged; load at addr 0x13 -> err_o pulse, rdata_o unchanged.
- Reset mid-store: store 0xAAAA5555 to 0x8 and drop rst_i at T+2 -> no ack_o; a later load of 0x8 returns its previous value.
- LATENCY=1 build: load at T -> stall_o=1 in cycle T only, ack_o and valid rdata_o in T+1; a request held through DONE is not re-accepted (exactly one ack_o).

Source files
------------

// File: rtl/data_memory_mc.sv
// Multi-cycle data memory responder for the MEM stage.
// Accepts one word load or store per instruction, holds the pipeline with stall_o for LATENCY
// cycles, then pulses ack_o with load data on rdata_o. Malformed requests pulse err_o instead.
//
// Ports:
//   clk_i      clock, rising edge
//   rst_i      asynchronous active-low reset
//   MemRead_i  load request
//   MemWrite_i store request
//   addr_i     byte address; word index is addr_i[ADDR_W+1:2], upper bits wrap
//   wdata_i    store data
//   rdata_o    load data, valid while ack_o=1 after a load; held otherwise
//   stall_o    pipeline hold (combinational)
//   ack_o      one-cycle completion pulse
//   err_o      one-cycle rejected-request pulse
module data_memory_mc #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        ack_o,
  output logic        err_o
);

  localparam int unsigned ADDR_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CntW   = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e              state_q;
  logic [CntW-1:0]     cnt_q;
  logic                op_write_q;
  logic [ADDR_W-1:0]   idx_q;
  logic [31:0]         wdata_q;

  // Zero at time 0; never cleared by reset.
  logic [31:0] mem_q [DEPTH_WORDS] = '{default: '0};

  logic              valid_req;
  logic              bad_req;
  logic [ADDR_W-1:0] req_idx;
  logic              acc_en;
  logic              acc_write;
  logic [ADDR_W-1:0] acc_idx;
  logic [31:0]       acc_wdata;
  logic              unused_addr;

  assign valid_req   = (MemRead_i ^ MemWrite_i) && (addr_i[1:0] == 2'b00);
  assign bad_req     = (MemRead_i && MemWrite_i) ||
                       ((MemRead_i || MemWrite_i) && (addr_i[1:0] != 2'b00));
  assign req_idx     = addr_i[ADDR_W+1:2];
  assign unused_addr = ^addr_i[31:ADDR_W+2];

  // Held low during reset so a request on the bus cannot freeze the pipeline.
  assign stall_o = rst_i && (((state_q == StIdle) && valid_req) || (state_q == StBusy));

  // With LATENCY=1 the access happens on the accepting edge, straight from the inputs;
  // otherwise it uses the latched request on the last BUSY edge.
  always_comb begin
    acc_en    = 1'b0;
    acc_write = op_write_q;
    acc_idx   = idx_q;
    acc_wdata = wdata_q;
    if (LATENCY == 1) begin
      acc_en    = rst_i && (state_q == StIdle) && valid_req;
      acc_write = MemWrite_i;
      acc_idx   = req_idx;
      acc_wdata = wdata_i;
    end else begin
      acc_en    = rst_i && (state_q == StBusy) && (cnt_q == CntW'(1));
    end
  end

  always_ff @(posedge clk_i) begin
    if (acc_en && acc_write) begin
      mem_q[acc_idx] <= acc_wdata;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      op_write_q <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      rdata_o    <= '0;
      ack_o      <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      ack_o <= 1'b0;
      err_o <= 1'b0;
      if (acc_en && !acc_write) begin
        rdata_o <= mem_q[acc_idx];
      end
      unique case (state_q)
        StIdle: begin
          if (valid_req) begin
            op_write_q <= MemWrite_i;
            idx_q      <= req_idx;
            wdata_q    <= wdata_i;
            cnt_q      <= CntW'(LATENCY - 1);
            if (LATENCY == 1) begin
              state_q <= StDone;
              ack_o   <= 1'b1;
            end else begin
              state_q <= StBusy;
            end
          end else if (bad_req) begin
            err_o <= 1'b1;
          end
        end
        StBusy: begin
          cnt_q <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            state_q <= StDone;
            ack_o   <= 1'b1;
          end
        end
        // Any request still present belongs to the completed instruction.
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_mc.sv
module tb_data_memory_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd4, wr4, rd1, wr1;
  logic [31:0] addr4, wdata4, addr1, wdata1;
  logic [31:0] rdata4, rdata1;
  logic        stall4, ack4, err4, stall1, ack1, err1;

  int total = 0;
  int bad   = 0;

  logic [31:0] sb [$];
  logic [31:0] m4 [int];
  logic [31:0] m1 [int];
  logic [31:0] last4, last1;

  always #5 clk = ~clk;

  data_memory_mc #(.DEPTH_WORDS(256), .LATENCY(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .MemRead_i(rd4), .MemWrite_i(wr4), .addr_i(addr4),
    .wdata_i(wdata4), .rdata_o(rdata4), .stall_o(stall4), .ack_o(ack4), .err_o(err4)
  );

  data_memory_mc #(.DEPTH_WORDS(16), .LATENCY(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .MemRead_i(rd1), .MemWrite_i(wr1), .addr_i(addr1),
    .wdata_i(wdata1), .rdata_o(rdata1), .stall_o(stall1), .ack_o(ack1), .err_o(err1)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] wd);
    if (sel) begin
      rd1 = rd; wr1 = wr; addr1 = a; wdata1 = wd;
    end else begin
      rd4 = rd; wr4 = wr; addr4 = a; wdata4 = wd;
    end
  endtask

  function automatic logic o_ack(input bit sel);
    return sel ? ack1 : ack4;
  endfunction
  function automatic logic o_stall(input bit sel);
    return sel ? stall1 : stall4;
  endfunction
  function automatic logic [31:0] o_rdata(input bit sel);
    return sel ? rdata1 : rdata4;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Valid access: model update / scoreboard push on drive, pop on ack.
  task automatic access(input bit sel, input bit rd, input logic [31:0] a,
                        input logic [31:0] wd, input bit idle_after);
    int          lat   = sel ? 1 : 4;
    int          idx   = sel ? int'((a >> 2) % 16) : int'((a >> 2) % 256);
    int          stalls = 0;
    bit          got   = 1'b0;
    logic [31:0] exp;
    drive(sel, rd, !rd, a, wd);
    if (rd) begin
      if (sel) sb.push_back(m1.exists(idx) ? m1[idx] : 32'h0);
      else     sb.push_back(m4.exists(idx) ? m4[idx] : 32'h0);
    end else begin
      if (sel) m1[idx] = wd;
      else     m4[idx] = wd;
    end
    for (int i = 0; i < lat + 3 && !got; i++) begin
      @(negedge clk);
      if (o_ack(sel)) got = 1'b1;
      else begin
        if (o_stall(sel)) stalls++;
        tick();
      end
    end
    chk("ack_seen", 32'(got), 32'd1);
    chk("stall_cycles", stalls, lat);
    chk("stall_in_done", 32'(o_stall(sel)), 32'd0);
    if (rd && sb.size() > 0) begin
      exp = sb.pop_front();
      chk("load_data", o_rdata(sel), exp);
      if (sel) last1 = exp;
      else     last4 = exp;
    end else begin
      chk("rdata_hold", o_rdata(sel), sel ? last1 : last4);
    end
    tick();
    drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
    if (idle_after) begin
      @(negedge clk);
      chk("no_reaccept_ack", 32'(o_ack(sel)), 32'd0);
      chk("no_reaccept_stall", 32'(o_stall(sel)), 32'd0);
      tick();
    end
  endtask

  task automatic reject(input bit rd, input bit wr, input logic [31:0] a);
    drive(1'b0, rd, wr, a, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("rej_stall", 32'(stall4), 32'd0);
    chk("rej_err_early", 32'(err4), 32'd0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("rej_err", 32'(err4), 32'd1);
    chk("rej_ack", 32'(ack4), 32'd0);
    chk("rej_rdata", rdata4, last4);
    tick();
    @(negedge clk);
    chk("rej_err_pulse", 32'(err4), 32'd0);
    tick();
  endtask

  initial begin
    rst = 1'b0;
    last4 = '0;
    last1 = '0;
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
    repeat (3) begin
      @(negedge clk);
      chk("rst_stall", 32'(stall4), 32'd0);
      chk("rst_rdata", rdata4, 32'h0);
      chk("rst_ack", 32'(ack4), 32'd0);
      chk("rst_stall1", 32'(stall1), 32'd0);
    end
    tick();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) begin
      @(negedge clk);
      chk("idle_outs", {rdata4[29:0], stall4, ack4} | {31'h0, err4}, 32'h0);
      tick();
    end

    // Back-to-back store then load.
    access(1'b0, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0);
    access(1'b0, 1'b1, 32'h10, 32'h0, 1'b0);
    // Wrap and unwritten word.
    access(1'b0, 1'b0, 32'h400, 32'h1234_5678, 1'b0);
    access(1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
    access(1'b0, 1'b1, 32'h20, 32'h0, 1'b1);
    // Rejects.
    reject(1'b1, 1'b1, 32'h20);
    access(1'b0, 1'b1, 32'h20, 32'h0, 1'b0);
    access(1'b0, 1'b1, 32'h0, 32'h0, 1'b1);
    reject(1'b1, 1'b0, 32'h13);
    reject(1'b0, 1'b1, 32'h2);

    // Reset mid-store: old value must survive.
    access(1'b0, 1'b0, 32'h8, 32'h1111_1111, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 32'h8, 32'hAAAA_5555);
    tick();
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    last4 = '0;
    last1 = '0;
    repeat (3) begin
      @(negedge clk);
      chk("midrst_ack", 32'(ack4), 32'd0);
      chk("midrst_stall", 32'(stall4), 32'd0);
      chk("midrst_rdata", rdata4, 32'h0);
      tick();
    end
    rst = 1'b1;
    tick();
    access(1'b0, 1'b1, 32'h8, 32'h0, 1'b1);

    // LATENCY=1 instance; request held through DONE must not be re-accepted.
    access(1'b1, 1'b0, 32'h4, 32'hCAFE_F00D, 1'b1);
    access(1'b1, 1'b1, 32'h4, 32'h0, 1'b1);
    access(1'b1, 1'b0, 32'h44, 32'h0BAD_F00D, 1'b0);
    access(1'b1, 1'b1, 32'h4, 32'h0, 1'b1);

    chk("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
